// File: rtl/arith_pkg.sv
// Shared types and constants for the serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bit-counter width for a WIDTH-bit serial operation (counts 0..WIDTH-1).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/single_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin with borrow-out.
module single_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, valid/ready on both sides.
// Signed overflow flag is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned MSB   = WIDTH - 1;

    sub_state_t       r_state;
    sub_state_t       w_state_next;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bin;
    logic             r_borrow;
    logic             r_out_valid;
    logic             w_xb;
    logic             w_yb;
    logic             w_db;
    logic             w_bout;
    logic             w_last;
    logic             w_load;
    logic             w_shift;
    logic             w_commit;
    logic             w_release;

    assign w_xb   = r_x[r_cnt];
    assign w_yb   = r_y[r_cnt];
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    single_subtractor u_cell (
        .x    (w_xb),
        .y    (w_yb),
        .bin  (r_bin),
        .d    (w_db),
        .bout (w_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)                  w_state_next = SHIFT;
            SHIFT:   if (w_last)                    w_state_next = DONE;
            DONE:    if (r_out_valid && out_ready)  w_state_next = IDLE;
            default:                                w_state_next = IDLE;
        endcase
    end

    // DONE spends one cycle committing the result before out_valid rises.
    always_comb begin
        in_ready  = 1'b0;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        w_commit  = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_load   = in_valid;
            end
            SHIFT: w_shift = 1'b1;
            DONE: begin
                w_commit  = ~r_out_valid;
                w_release = r_out_valid & out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_bin       <= 1'b0;
            r_d         <= '0;
            r_borrow    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_x   <= x;
                r_y   <= y;
                r_res <= '0;
                r_cnt <= '0;
                r_bin <= 1'b0;
            end
            if (w_shift) begin
                r_res <= {w_db, r_res[WIDTH-1:1]};
                r_bin <= w_bout;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_commit) begin
                r_d         <= r_res;
                r_borrow    <= r_bin;
                r_out_valid <= 1'b1;
            end
            if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign d         = r_d;
    assign borrow    = r_borrow;
    assign out_valid = r_out_valid;

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_commit) begin
            r_ovf <= (r_x[MSB] != r_y[MSB]) && (r_res[MSB] != r_x[MSB]);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] tx;
    logic [W-1:0] ty;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         borrow;
    logic         ovf;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (tx),
        .y         (ty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.d      = a - b;
        e.borrow = (a < b);
`ifdef SERIAL_SUB_OVF_EN
        e.ovf    = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
`else
        e.ovf    = 1'b0;
`endif
        return e;
    endfunction

    // Present operands for one edge; caller is positioned away from the edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        tx       = a;
        ty       = b;
        in_valid = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tx       = '0;
        ty       = '0;
    endtask

    // Wait for out_valid; start = edges already elapsed since accept.
    task automatic wait_result(input string tag, input int start);
        int n;
        n = start;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        check({tag, "_latency"}, 32'(n), 32'(W + 1));
        if (!out_valid) begin
            check({tag, "_timeout"}, 32'(out_valid), 32'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            cur = sb.pop_front();
            check({tag, "_d"}, 32'(d), 32'(cur.d));
            check({tag, "_borrow"}, 32'(borrow), 32'(cur.borrow));
            check({tag, "_ovf"}, 32'(ovf), 32'(cur.ovf));
        end
    endtask

    // Hold out_ready low for `hold` cycles, then hand off and confirm IDLE.
    task automatic take(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_d"}, 32'(d), 32'(cur.d));
            check({tag, "_hold_borrow"}, 32'(borrow), 32'(cur.borrow));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tx        = '0;
        ty        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send(8'd200, 8'd55);
        check("shift_in_ready", 32'(in_ready), 32'd0);
        wait_result("op200_55", 0);
        take("op200_55", 0);

        send(8'd5, 8'd10);
        wait_result("op5_10", 0);
        take("op5_10", 0);

        send(8'd0, 8'd0);
        wait_result("op0_0", 0);
        take("op0_0", 0);

        send(8'h80, 8'h01);
        wait_result("op80_01", 0);
        take("op80_01", 0);

        send(8'h7F, 8'hFF);
        wait_result("op7f_ff", 0);
        take("op7f_ff", 0);

        send(8'h10, 8'h01);
        wait_result("op10_01", 0);
        take("op10_01", 0);

        // Back-pressure: result must hold for 5 cycles.
        send(8'd100, 8'd30);
        wait_result("stall", 0);
        take("stall", 5);

        // Operands offered mid-SHIFT must be ignored.
        send(8'd200, 8'd55);
        tx       = 8'd1;
        ty       = 8'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tx       = '0;
        ty       = '0;
        check("ignore_in_ready", 32'(in_ready), 32'd0);
        wait_result("ignore", 1);
        take("ignore", 0);
        check("ignore_no_extra", 32'(out_valid), 32'd0);

        // Abort in the 4th SHIFT cycle.
        send(8'd123, 8'd45);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        send(8'd9, 8'd3);
        wait_result("op9_3", 0);
        take("op9_3", 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operands x, y presented.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: x  input  WIDTH  minuend.
REQ-007 SHALL have port: y  input  WIDTH  subtrahend.
REQ-008 SHALL have port: out_valid  output  1  result d/borrow/ovf valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: d  output  WIDTH  difference x - y modulo 2^WIDTH.
REQ-011 SHALL have port: borrow  output  1  unsigned borrow-out (1 iff x < y unsigned).
REQ-012 SHALL have port: ovf  output  1  signed two's-complement overflow flag.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE, combinationally from state.
REQ-015 SHALL, on an edge with in_valid && in_ready, latch x, y, clear the borrow flop, load bit counter with 0, enter SHIFT.
REQ-016 SHALL, in SHIFT, process one bit per cycle LSB first through a one-bit full-subtractor cell, shifting the difference bit into the result register MSB-ward and registering the borrow.
REQ-017 SHALL leave SHIFT after exactly WIDTH SHIFT cycles; out_valid SHALL rise WIDTH+1 edges after the accept edge.
REQ-018 SHALL, in DONE, hold out_valid = 1 and d, borrow, ovf stable until an edge with out_ready = 1.
REQ-019 SHALL, on out_valid && out_ready, return to IDLE; in_ready SHALL be 1 in the following cycle; no accept in the same cycle as result hand-off.
REQ-020 SHALL ignore in_valid, x, y while in SHIFT or DONE.
REQ-021 SHALL compute borrow as the final registered borrow-out of the MSB cell.
REQ-022 SHALL keep d, borrow, ovf at their last values outside DONE; outputs are only meaningful while out_valid = 1.
REQ-023 SHALL compute ovf = (x[MSB] != y[MSB]) && (d[MSB] != x[MSB]) when enabled (REQ-027).

Reset
REQ-024 SHALL, while rst = 1, force state IDLE, out_valid 0, d 0, borrow 0, ovf 0, counter 0, operand registers 0; in_ready reads 1.
REQ-025 SHALL abort any in-flight operation on rst assertion mid-SHIFT or mid-DONE; no result is produced for it.
REQ-026 SHALL accept new operands on the first edge after rst deasserts if in_valid = 1.

Configuration
REQ-027 SHALL compile signed overflow detection only when macro SERIAL_SUB_OVF_EN is defined; without it ovf SHALL be tied to 0 and no overflow logic or flop SHALL exist.

Structure
REQ-028 SHALL place FSM state enumeration and counter-width constant (clog2 of WIDTH) in shared package arith_pkg.
REQ-029 SHALL instantiate one sub-module single_subtractor (inputs x, y, bin; outputs d, bout; d = x^y^bin, bout = (~x&y) | (~(x^y)&bin)).
REQ-030 SHALL contain no combinational path from x, y, in_valid to any output other than none; in_ready depends on state only.

Verification
REQ-031 SHALL verify: WIDTH=8, x=200, y=55 -> d=145, borrow=0, out_valid exactly 9 edges after accept.
REQ-032 SHALL verify: x=5, y=10 -> d=251, borrow=1; x=0, y=0 -> d=0, borrow=0.
REQ-033 SHALL verify: with SERIAL_SUB_OVF_EN, x=0x80, y=0x01 -> d=0x7F, ovf=1; x=0x7F, y=0xFF -> d=0x80, ovf=1; x=0x10, y=0x01 -> ovf=0; without macro ovf=0 throughout.
REQ-034 SHALL verify: out_ready held 0 for 5 cycles in DONE -> out_valid, d, borrow stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL verify: in_valid pulsed with x=1, y=2 during SHIFT of 200-55 -> ignored, result still 145.
REQ-036 SHALL verify: rst asserted at 4th SHIFT cycle -> out_valid 0, in_ready 1 immediately; next op 9-3 -> d=6, borrow=0.
